// File: rtl/vram_word_fetch.sv
// Fetches 16-bit words as little-endian byte pairs from a synchronous vector RAM into a 2-entry output FIFO.
// Optional HALT-opcode run termination is enabled by defining VFETCH_HALT_EN.
module vram_word_fetch #(
    parameter int AW = 10,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] start_addr,
    input  logic          stop,
    output logic          busy,
    output logic [AW-1:0] ram_addr,
    input  logic [DW-1:0] ram_q,
    output logic [15:0]   word_out,
    output logic          word_valid,
    input  logic          word_ready
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RD_LO = 2'd1;
    localparam logic [1:0] RD_HI = 2'd2;
    localparam logic [1:0] WAIT  = 2'd3;

    localparam logic [AW-1:0] ADDR_ONE  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0] EVEN_MASK = {{(AW-1){1'b1}}, 1'b0};

    logic [1:0]    state_r,   state_s;
    logic [AW-1:0] ram_addr_r, ram_addr_s;
    logic          lo_pend_r, lo_pend_s;
    logic          hi_pend_r, hi_pend_s;
    logic [DW-1:0] lo_byte_r, lo_byte_s;
    logic [1:0]    count_r,   count_s;
    logic [15:0]   e0_r,      e0_s;
    logic [15:0]   e1_r,      e1_s;
    logic          busy_r,    busy_s;
    logic          valid_r,   valid_s;

    logic          pop_s;
    logic          push_s;
    logic          halt_s;
    logic [1:0]    slot_s;
    logic [1:0]    count_nx_s;
    logic [15:0]   push_word_s;

    // HALT opcode detection on the word being pushed this cycle
`ifdef VFETCH_HALT_EN
    assign halt_s = hi_pend_r && (ram_q[DW-1:DW-3] == 3'b001);
`else
    assign halt_s = 1'b0;
`endif

    // FIFO bookkeeping: pop from the head, push into the first free slot after the pop
    always_comb begin
        pop_s       = (count_r != 2'd0) && word_ready;
        push_s      = hi_pend_r;
        push_word_s = {ram_q, lo_byte_r};
        count_nx_s  = count_r + {1'b0, push_s} - {1'b0, pop_s};
        slot_s      = count_r - {1'b0, pop_s};
        lo_byte_s   = lo_pend_r ? ram_q : lo_byte_r;
        if (pop_s) begin
            e0_s = e1_r;
        end else begin
            e0_s = e0_r;
        end
        e1_s = e1_r;
        if (push_s) begin
            if (slot_s == 2'd0) begin
                e0_s = push_word_s;
            end else begin
                e1_s = push_word_s;
            end
        end else begin
            e1_s = e1_r;
        end
    end

    // Read sequencer; a new word is issued only if it still fits in the FIFO once it lands
    always_comb begin
        state_s    = state_r;
        ram_addr_s = ram_addr_r;
        count_s    = count_nx_s;
        lo_pend_s  = (state_r == RD_LO);
        hi_pend_s  = (state_r == RD_HI);
        case (state_r)
            IDLE: begin
                if (start && !busy_r) begin
                    state_s    = RD_LO;
                    ram_addr_s = start_addr & EVEN_MASK;
                end else begin
                    state_s    = IDLE;
                end
            end
            RD_LO: begin
                state_s    = RD_HI;
                ram_addr_s = ram_addr_r + ADDR_ONE;
            end
            RD_HI: begin
                // the word just read is still in flight, so only an empty FIFO admits another
                if (count_nx_s == 2'd0) begin
                    state_s    = RD_LO;
                    ram_addr_s = ram_addr_r + ADDR_ONE;
                end else begin
                    state_s    = WAIT;
                end
            end
            WAIT: begin
                if (count_nx_s != 2'd2) begin
                    state_s    = RD_LO;
                    ram_addr_s = ram_addr_r + ADDR_ONE;
                end else begin
                    state_s    = WAIT;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        // a HALT word cancels the read already issued behind it; the FIFO drains normally
        if (halt_s) begin
            state_s   = IDLE;
            lo_pend_s = 1'b0;
            hi_pend_s = 1'b0;
        end else begin
            lo_pend_s = lo_pend_s;
        end

        if (stop) begin
            state_s   = IDLE;
            lo_pend_s = 1'b0;
            hi_pend_s = 1'b0;
            count_s   = 2'd0;
        end else begin
            count_s   = count_nx_s;
        end

        busy_s  = (state_s != IDLE) || (count_s != 2'd0);
        valid_s = (count_s != 2'd0);
    end

    // State, FIFO and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            ram_addr_r <= '0;
            lo_pend_r  <= 1'b0;
            hi_pend_r  <= 1'b0;
            lo_byte_r  <= '0;
            count_r    <= 2'd0;
            e0_r       <= 16'd0;
            e1_r       <= 16'd0;
            busy_r     <= 1'b0;
            valid_r    <= 1'b0;
        end else begin
            state_r    <= state_s;
            ram_addr_r <= ram_addr_s;
            lo_pend_r  <= lo_pend_s;
            hi_pend_r  <= hi_pend_s;
            lo_byte_r  <= lo_byte_s;
            count_r    <= count_s;
            e0_r       <= stop ? 16'd0 : e0_s;
            e1_r       <= stop ? 16'd0 : e1_s;
            busy_r     <= busy_s;
            valid_r    <= valid_s;
        end
    end

    assign busy       = busy_r;
    assign ram_addr   = ram_addr_r;
    assign word_out   = e0_r;
    assign word_valid = valid_r;

endmodule
